// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg                                                            |
// | Shared ALU definitions: sequencer state encoding, nibble width and |
// | status-register flag indices.                                      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions of the flags in the ALU status register
  localparam int FLAG_BORROW   = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_COUNT    = 3;

endpackage
`default_nettype wire

// File: rtl/nibble_add_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nibble_add_stage                                                   |
// | Combinational 4-bit adder with carry in/out; the single arithmetic |
// | stage reused on every cycle of the serial subtractor.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module nibble_add_stage
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out
);

  // Widen by one bit so the carry falls out of the top of the sum
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, c_in};

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_subtractor                                                  |
// | Computes a - b one nibble per clock as a + ~b + 1, keeping the     |
// | carry in a register between cycles. start/ready/result_valid       |
// | handshake toward the ALU issue logic.                              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             result_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = $clog2(NIBBLES);

  state_t                  state;
  logic [CNT_W-1:0]        count;
  logic                    carry;
  logic [WIDTH-1:0]        a_r;
  logic [WIDTH-1:0]        b_r;   // holds ~b so the stage only ever adds
  logic [FLAG_COUNT-1:0]   flags;

  logic [NIBBLE_W-1:0]     nib_a;
  logic [NIBBLE_W-1:0]     nib_b;
  logic [NIBBLE_W-1:0]     nib_sum;
  logic                    nib_carry;
  logic                    last_nibble;
  logic                    final_zero;
  logic                    final_overflow;

  assign nib_a       = a_r[count*NIBBLE_W +: NIBBLE_W];
  assign nib_b       = b_r[count*NIBBLE_W +: NIBBLE_W];
  assign last_nibble = (count == CNT_W'(NIBBLES - 1));

  nibble_add_stage u_stage (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (carry),
    .sum   (nib_sum),
    .c_out (nib_carry)
  );

  // On the last edge the top nibble is still in flight, so zero looks at
  // the already-written lower nibbles plus the sum being written now.
  assign final_zero = (nib_sum == '0) && (diff[WIDTH-NIBBLE_W-1:0] == '0);

  // Original b sign is the inverse of the stored complemented operand
  assign final_overflow = (a_r[WIDTH-1] != ~b_r[WIDTH-1]) &&
                          (nib_sum[NIBBLE_W-1] != a_r[WIDTH-1]);

  assign borrow_out = flags[FLAG_BORROW];
  assign overflow   = flags[FLAG_OVERFLOW];
  assign zero       = flags[FLAG_ZERO];

  // Sequencer: capture operands, walk the nibbles, pulse result_valid
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      ready        <= 1'b1;
      result_valid <= 1'b0;
      diff         <= '0;
      flags        <= '0;
      count        <= '0;
      carry        <= 1'b1;
      a_r          <= '0;
      b_r          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= ~b;
            carry <= 1'b1;
            count <= '0;
            ready <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          diff[count*NIBBLE_W +: NIBBLE_W] <= nib_sum;
          carry <= nib_carry;
          count <= count + 1'b1;
          if (last_nibble) begin
            flags[FLAG_BORROW]   <= ~nib_carry;
            flags[FLAG_OVERFLOW] <= final_overflow;
            flags[FLAG_ZERO]     <= final_zero;
            result_valid         <= 1'b1;
            state                <= ST_DONE;
          end
        end
        ST_DONE: begin
          result_valid <= 1'b0;
          ready        <= 1'b1;
          state        <= ST_IDLE;
        end
        default: begin
          result_valid <= 1'b0;
          ready        <= 1'b1;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_serial_subtractor                                               |
// | Table-driven and random self-checking bench for serial_subtractor. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_serial_subtractor;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             resetn;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             result_valid;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .a            (a),
    .b            (b),
    .ready        (ready),
    .result_valid (result_valid),
    .diff         (diff),
    .borrow_out   (borrow_out),
    .overflow     (overflow),
    .zero         (zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
    logic             z;
    bit               hold;   // keep start asserted while busy
    bit               scr;    // scramble a/b after acceptance
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                       output logic [WIDTH-1:0] md, output logic mbo,
                       output logic mov, output logic mz);
    longint sa;
    longint sb;
    longint sd;
    md  = ma - mb;
    mbo = (ma < mb);
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    sd  = sa - sb;
    mov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    mz  = (md == '0);
  endtask

  // One full operation with handshake and timing checks
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input bit hold, input bit scr,
                        output logic [WIDTH-1:0] rd, output logic rbo,
                        output logic rov, output logic rz);
    int k;
    @(negedge clock);
    check("ready_before_start", ready, 1'b1);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(posedge clock);
    #1;
    start = hold;
    if (scr) begin
      a = $urandom;
      b = $urandom;
    end
    k = 0;
    @(negedge clock);
    while (!result_valid && k < 20) begin
      check("ready_low_busy", ready, 1'b0);
      if (scr) begin
        a = $urandom;
        b = $urandom;
      end
      @(negedge clock);
      k++;
    end
    check("valid_seen", result_valid, 1'b1);
    check("latency", 64'(k), 64'd8);
    check("ready_low_at_valid", ready, 1'b0);
    rd  = diff;
    rbo = borrow_out;
    rov = overflow;
    rz  = zero;
    @(negedge clock);
    start = 1'b0;
    check("valid_single_pulse", result_valid, 1'b0);
    check("ready_after_valid", ready, 1'b1);
    check("diff_holds", diff, rd);
    @(negedge clock);
    check("no_second_pulse", result_valid, 1'b0);
    check("ready_stays_idle", ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] gd;
    logic             gbo, gov, gz;
    logic [WIDTH-1:0] md;
    logic             mbo, mov, mz;
    int               pulses;

    vecs[0] = '{32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0064, 32'h0000_0032, 32'h0000_0032, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    resetn = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    #12;
    check("rst_ready", ready, 1'b1);
    check("rst_valid", result_valid, 1'b0);
    check("rst_diff", diff, 32'h0);
    check("rst_borrow", borrow_out, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_zero", zero, 1'b0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].scr, gd, gbo, gov, gz);
      check($sformatf("vec%0d_diff", i), gd, vecs[i].d);
      check($sformatf("vec%0d_borrow", i), gbo, vecs[i].bo);
      check($sformatf("vec%0d_overflow", i), gov, vecs[i].ov);
      check($sformatf("vec%0d_zero", i), gz, vecs[i].z);
    end

    // Reset in the middle of RUN, while count is 3
    @(negedge clock);
    start = 1'b1;
    a     = 32'hFFFF_FFFF;
    b     = 32'h0000_0000;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("midrun_busy", ready, 1'b0);
    resetn = 1'b0;
    #1;
    check("midrst_ready", ready, 1'b1);
    check("midrst_diff", diff, 32'h0);
    check("midrst_valid", result_valid, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (result_valid) pulses++;
    end
    check("midrst_no_pulse", 64'(pulses), 64'd0);
    check("midrst_idle_ready", ready, 1'b1);
    run_op(32'd5, 32'd3, 1'b0, 1'b0, gd, gbo, gov, gz);
    check("after_rst_diff", gd, 32'h2);
    check("after_rst_borrow", gbo, 1'b0);

    // Random operands against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
      if ($urandom_range(0, 5) == 0) rb = {~ra[31], rb[30:0]};
      model(ra, rb, md, mbo, mov, mz);
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gd, gbo, gov, gz);
      check("rand_diff", gd, md);
      check("rand_borrow", gbo, mbo);
      check("rand_overflow", gov, mov);
      check("rand_zero", gz, mz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
